// File: rtl/ram_test_initiator.sv
// ram_test_initiator
// ------------------
// Built-in memory test engine that sits beside a single-port RAM and drives
// it over a valid/ready request interface. On an accepted start pulse it
// writes exp(a) = seed ^ a to every address 0..DEPTH-1. It then reads every
// address back, compares the result with exp(a), and reports the outcome.
//
// Handshake (initiator side): valid is a one-cycle request strobe, and
// addr/wr_rd/wdata are held stable from that cycle until the acknowledge.
// The RAM answers with ready=1 one cycle after it samples valid. On a read,
// rdata is meaningful only while ready=1. ready is only consumed in the
// WAIT states, so an acknowledge that lines up with a request cycle has no
// effect. If ready does not arrive within TIMEOUT wait cycles, the sweep is
// abandoned.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, seed     begin a test (sampled only when idle), pattern seed
//   valid, wr_rd    request strobe, 1 = write / 0 = read
//   addr, wdata     request address and write data
//   ready, rdata    RAM acknowledge and read data
//   busy, done      test in progress, one-cycle end-of-test pulse
//   pass            last test had no mismatch and no timeout
//   err_count       mismatches seen in the last test (saturates at DEPTH)
//   first_err_addr  address of the first mismatch
//   timeout_err     last test was aborted waiting for ready
module ram_test_initiator #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic                  ready,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout_err
);

  // Width used to zero-extend the address before truncating it to WIDTH.
  localparam int MAXW = (WIDTH > ADDR_WIDTH) ? WIDTH : ADDR_WIDTH;
  // The wait counter runs 0..TIMEOUT-1.
  localparam int CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ERR_MAX   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CW-1:0]         WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      seed_q;
  logic [CW-1:0]         wait_cnt;

  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  last_addr;
  logic                  wait_expired;
  logic                  mismatch;
  logic [ADDR_WIDTH:0]   err_next;

  // Expected data for address a: seed XOR a, with a zero-extended or
  // truncated to the data width.
  function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0]      s,
                                               input logic [ADDR_WIDTH-1:0] a);
    logic [MAXW-1:0] a_ext;
    a_ext = MAXW'(a);
    return s ^ a_ext[WIDTH-1:0];
  endfunction

  always_comb begin
    addr_next    = addr + ADDR_WIDTH'(1);
    last_addr    = (addr == LAST_ADDR);
    wait_expired = (wait_cnt == WAIT_LAST);
    mismatch     = (rdata != pattern(seed_q, addr));
    err_next     = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      valid          <= 1'b0;
      wr_rd          <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout_err    <= 1'b0;
      seed_q         <= '0;
      wait_cnt       <= '0;
    end else begin
      // valid and done default low. They are raised only on entry to a
      // request state or to FIN. This keeps both strobes one cycle wide.
      valid <= 1'b0;
      done  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            seed_q         <= seed;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            timeout_err    <= 1'b0;
            addr           <= '0;
            busy           <= 1'b1;
            valid          <= 1'b1;
            wr_rd          <= 1'b1;
            wdata          <= pattern(seed, '0);
            state          <= WR_REQ;
          end
        end

        WR_REQ: begin
          wait_cnt <= '0;
          state    <= WR_WAIT;
        end

        WR_WAIT: begin
          if (ready) begin
            wait_cnt <= '0;
            valid    <= 1'b1;
            if (last_addr) begin
              addr  <= '0;
              wr_rd <= 1'b0;
              state <= RD_REQ;
            end else begin
              addr  <= addr_next;
              wdata <= pattern(seed_q, addr_next);
              state <= WR_REQ;
            end
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            pass        <= 1'b0;
            done        <= 1'b1;
            state       <= FIN;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        RD_REQ: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end

        RD_WAIT: begin
          if (ready) begin
            wait_cnt  <= '0;
            err_count <= err_next;
            if (mismatch && (err_count == '0)) begin
              first_err_addr <= addr;
            end
            if (last_addr) begin
              addr  <= '0;
              // err_next already includes this final comparison.
              pass  <= (err_next == '0);
              done  <= 1'b1;
              state <= FIN;
            end else begin
              addr  <= addr_next;
              valid <= 1'b1;
              state <= RD_REQ;
            end
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            pass        <= 1'b0;
            done        <= 1'b1;
            state       <= FIN;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        FIN: begin
          // A start pulse that arrives in this cycle is dropped. A new test
          // has to be requested from IDLE.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_test_initiator.sv
// Testbench for ram_test_initiator. It contains a behavioural RAM responder
// and a scoreboard. For each issued test, the scoreboard queues the expected
// bus transactions and the expected final result. Monitors pop and compare
// whenever the DUT strobes valid or done. A second instance with DEPTH=10
// covers a sweep length that is not a power of two.
module tb_ram_test_initiator;
  localparam int W   = 8;
  localparam int AW  = 4;
  localparam int D   = 16;
  localparam int TO  = 8;
  localparam int DB  = 10;
  localparam int TW  = 1 + AW + W;

  typedef struct packed {
    logic        to;
    logic        ps;
    logic [AW:0] ec;
    logic [AW-1:0] fe;
    logic [7:0]  nv;
    logic [31:0] cyc;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0, start_b = 1'b0;
  logic [W-1:0]  seed = '0, seed_b = '0;

  logic          valid, wr_rd, ready, busy, done, pass, timeout_err;
  logic [AW-1:0] addr, first_err_addr;
  logic [W-1:0]  wdata, rdata;
  logic [AW:0]   err_count;

  logic          valid_b, wr_rd_b, ready_b, busy_b, done_b, pass_b, timeout_err_b;
  logic [AW-1:0] addr_b, first_err_addr_b;
  logic [W-1:0]  wdata_b, rdata_b;
  logic [AW:0]   err_count_b;

  ram_test_initiator #(.DEPTH(D), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .timeout_err(timeout_err)
  );

  ram_test_initiator #(.DEPTH(DB), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seed(seed_b),
    .valid(valid_b), .wr_rd(wr_rd_b), .addr(addr_b), .wdata(wdata_b),
    .ready(ready_b), .rdata(rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_count_b), .first_err_addr(first_err_addr_b), .timeout_err(timeout_err_b)
  );

  int cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // ---------------- RAM responders ----------------
  logic [W-1:0] mem   [D];
  logic [W-1:0] mem_b [D];
  logic [W-1:0] flip  [D];
  int           stall_addr = -1;
  logic         stale = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
    end else if (valid && !(wr_rd && int'(addr) == stall_addr)) begin
      ready <= 1'b1;
      if (wr_rd) mem[addr] <= wdata;
      else       rdata <= mem[addr] ^ flip[addr];
    end else begin
      ready <= stale;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      ready_b <= 1'b0;
    end else if (valid_b) begin
      ready_b <= 1'b1;
      if (wr_rd_b) mem_b[addr_b] <= wdata_b;
      else         rdata_b <= mem_b[addr_b];
    end else begin
      ready_b <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] exp_b_q[$];
  res_t          res_q[$];
  res_t          res_b_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            vcount = 0;
  int            vcount_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: derive the full transaction list and the final result
  // directly from the sweep rules, then pulse start.
  task automatic issue_test(input logic [W-1:0] s);
    res_t r;
    int errs, first, n;
    r = '0; errs = 0; first = -1; n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    for (int a = 0; a < D; a++) begin
      exp_q.push_back({1'b1, AW'(a), W'(s ^ W'(a))});
      if (a == stall_addr) begin
        r.to  = 1'b1;
        r.nv  = 8'(a + 1);
        r.cyc = 32'(2 * a + TO + 2);
        break;
      end
    end
    if (!r.to) begin
      for (int a = 0; a < D; a++) begin
        exp_q.push_back({1'b0, AW'(a), W'(0)});
        if (flip[a] != '0) begin
          errs++;
          if (first < 0) first = a;
        end
      end
      r.nv  = 8'(2 * D);
      r.cyc = 32'(4 * D + 1);
    end
    r.ec  = (AW + 1)'(errs);
    r.fe  = (first < 0) ? '0 : AW'(first);
    r.ps  = !r.to && (errs == 0);
    r.cyc = r.cyc + 32'(cyc_now);
    res_q.push_back(r);
    vcount = 0;
    seed   = s;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic issue_test_b(input logic [W-1:0] s);
    res_t r;
    r = '0;
    for (int a = 0; a < DB; a++) exp_b_q.push_back({1'b1, AW'(a), W'(s ^ W'(a))});
    for (int a = 0; a < DB; a++) exp_b_q.push_back({1'b0, AW'(a), W'(0)});
    r.ps  = 1'b1;
    r.nv  = 8'(2 * DB);
    r.cyc = 32'(4 * DB + 1) + 32'(cyc_now);
    res_b_q.push_back(r);
    vcount_b = 0;
    seed_b   = s;
    start_b  = 1'b1;
    @(negedge clk);
    start_b  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((res_q.size() != 0 || res_b_q.size() != 0) && n < 500) begin
      @(negedge clk); n++;
    end
    check("test_finished", {31'b0, res_q.size() == 0 && res_b_q.size() == 0}, 1);
    exp_q.delete(); res_q.delete(); exp_b_q.delete(); res_b_q.delete();
    @(negedge clk);
  endtask

  task automatic clear_flips();
    for (int a = 0; a < D; a++) flip[a] = '0;
  endtask

  // ---------------- monitors ----------------
  logic          prev_valid = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic          hold_wr = 1'b0;
  logic [W-1:0]  hold_wdata = '0;

  always @(negedge clk) begin
    logic [TW-1:0] e;
    res_t r;
    if (valid) begin
      check("valid_gap", {31'b0, prev_valid}, 0);
      vcount++;
      hold_addr = addr; hold_wr = wr_rd; hold_wdata = wdata;
      check("txn_expected", {31'b0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_rd", {31'b0, wr_rd}, {31'b0, e[TW-1]});
        check("addr", {28'b0, addr}, {28'b0, e[W+AW-1:W]});
        if (e[TW-1]) check("wdata", {24'b0, wdata}, {24'b0, e[W-1:0]});
      end
    end else if (busy && !done) begin
      check("hold_addr", {28'b0, addr}, {28'b0, hold_addr});
      check("hold_wr_rd", {31'b0, wr_rd}, {31'b0, hold_wr});
      if (hold_wr) check("hold_wdata", {24'b0, wdata}, {24'b0, hold_wdata});
    end
    if (done) begin
      check("result_expected", {31'b0, res_q.size() != 0}, 1);
      if (res_q.size() != 0) begin
        r = res_q.pop_front();
        check("done_cycle", cyc_now, r.cyc);
        check("pass", {31'b0, pass}, {31'b0, r.ps});
        check("err_count", {27'b0, err_count}, {27'b0, r.ec});
        check("first_err_addr", {28'b0, first_err_addr}, {28'b0, r.fe});
        check("timeout_err", {31'b0, timeout_err}, {31'b0, r.to});
        check("valid_count", vcount, {24'b0, r.nv});
        check("txns_left", exp_q.size(), 0);
      end
    end
    prev_valid = valid;
  end

  always @(negedge clk) begin
    logic [TW-1:0] e;
    res_t r;
    if (valid_b) begin
      vcount_b++;
      check("addr_in_range_b", {31'b0, int'(addr_b) < DB}, 1);
      check("txn_expected_b", {31'b0, exp_b_q.size() != 0}, 1);
      if (exp_b_q.size() != 0) begin
        e = exp_b_q.pop_front();
        check("wr_rd_b", {31'b0, wr_rd_b}, {31'b0, e[TW-1]});
        check("addr_b", {28'b0, addr_b}, {28'b0, e[W+AW-1:W]});
        if (e[TW-1]) check("wdata_b", {24'b0, wdata_b}, {24'b0, e[W-1:0]});
      end
    end
    if (done_b) begin
      check("result_expected_b", {31'b0, res_b_q.size() != 0}, 1);
      if (res_b_q.size() != 0) begin
        r = res_b_q.pop_front();
        check("done_cycle_b", cyc_now, r.cyc);
        check("pass_b", {31'b0, pass_b}, {31'b0, r.ps});
        check("err_count_b", {27'b0, err_count_b}, 0);
        check("timeout_err_b", {31'b0, timeout_err_b}, 0);
        check("valid_count_b", vcount_b, {24'b0, r.nv});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [W-1:0] s;
    clear_flips();
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, valid}, 0);
    check("rst_wr_rd", {31'b0, wr_rd}, 0);
    check("rst_addr", {28'b0, addr}, 0);
    check("rst_wdata", {24'b0, wdata}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_pass", {31'b0, pass}, 0);
    check("rst_err_count", {27'b0, err_count}, 0);
    check("rst_first_err", {28'b0, first_err_addr}, 0);
    check("rst_timeout", {31'b0, timeout_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal sweep with a correct RAM.
    issue_test(8'hA5);
    wait_idle();

    // Two corrupted reads.
    flip[5] = 8'h01; flip[9] = 8'h01;
    issue_test(8'hA5);
    wait_idle();
    clear_flips();

    // RAM never acknowledges the write to address 2.
    stall_addr = 2;
    issue_test(W'($urandom));
    wait_idle();
    stall_addr = -1;

    // Reset in the read phase at address 7, with errors already counted.
    flip[1] = 8'h10; flip[3] = 8'h80;
    issue_test(W'($urandom));
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(valid && !wr_rd && addr == AW'(7)) && n < 200);
    check("reached_read_7", {31'b0, n < 200}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); res_q.delete();
    check("midrst_valid", {31'b0, valid}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_err_count", {27'b0, err_count}, 0);
    check("midrst_done", {31'b0, done}, 0);
    clear_flips();
    repeat (20) @(negedge clk);
    issue_test(W'($urandom));
    wait_idle();

    // Stale ready held high and start hammered while busy.
    stale = 1'b1;
    issue_test(8'hA5);
    n = 0;
    while (n < 200) begin
      @(negedge clk); n++;
      if (busy) start = 1'($urandom_range(0, 1));
      else begin start = 1'b0; break; end
    end
    check("hammer_finished", {31'b0, n < 200}, 1);
    stale = 1'b0;
    wait_idle();

    // Randomised tests: random seeds, corruption and stalls.
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < D; a++)
        flip[a] = (t == 7 || $urandom_range(0, 3) == 0) ? W'($urandom_range(1, 255)) : '0;
      stall_addr = ($urandom_range(0, 3) == 0 && t != 7) ? $urandom_range(0, D - 1) : -1;
      issue_test(W'($urandom));
      wait_idle();
    end
    stall_addr = -1;
    clear_flips();

    // DEPTH=10 instance: seed 0, then a random seed.
    issue_test_b('0);
    wait_idle();
    s = W'($urandom);
    issue_test_b(s);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_test_initiator.md
Name: ram_test_initiator

Overview:
- Initiator/master for the valid/ready single-port RAM interface.
- Runs a self-contained write-then-read-back sweep over all RAM addresses and compares each read against the expected pattern.
- Reports pass/fail, the error count and the first failing address.
- Sits beside the target RAM as a built-in memory test engine, driven by a start pulse from system control.

Parameters:
- DEPTH, 16: number of RAM words swept (need not be a power of two; DEPTH <= 2^ADDR_WIDTH).
- WIDTH, 8: RAM data width.
- ADDR_WIDTH, 4: RAM address width.
- TIMEOUT, 8: maximum cycles spent waiting for ready per transaction before abort (>= 1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  single-cycle request to begin a test; sampled only in IDLE.
- seed  input  WIDTH  pattern seed; captured when start is accepted.
- valid  output  1  request strobe to RAM.
- wr_rd  output  1  1 = write, 0 = read.
- addr  output  ADDR_WIDTH  RAM address.
- wdata  output  WIDTH  write data.
- ready  input  1  RAM acknowledge, asserted the cycle after RAM samples valid.
- rdata  input  WIDTH  RAM read data, valid while ready=1 on a read.
- busy  output  1  test in progress.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  1 = last test had zero mismatches and no timeout.
- err_count  output  ADDR_WIDTH+1  mismatches in last test.
- first_err_addr  output  ADDR_WIDTH  address of first mismatch.
- timeout_err  output  1  last test aborted on timeout.

Behaviour:
- Single clock, clk. Reset is synchronous, active-high on rst. All outputs registered.
- Reset values: valid=0, wr_rd=0, addr=0, wdata=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, timeout_err=0. FSM enters IDLE.
- States are IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FIN.
- Expected data: exp(a) = seed_q XOR a, with a zero-extended or truncated to WIDTH.
- IDLE:
  - start=1 captures seed into seed_q.
  - Clears err_count, first_err_addr, pass and timeout_err; sets addr=0 and busy=1.
  - Next state WR_REQ. start while busy is ignored.
- WR_REQ (1 cycle): valid=1, wr_rd=1, wdata=exp(addr). Next state WR_WAIT.
- WR_WAIT: valid=0.
  - ready=1: if addr==DEPTH-1, set addr=0 and go to RD_REQ; otherwise addr+1 and go to WR_REQ.
  - Nominal RAM returns ready on the first WAIT cycle, so each transaction takes 2 cycles.
- RD_REQ (1 cycle): valid=1, wr_rd=0. Next state RD_WAIT.
- RD_WAIT: valid=0. On ready=1, compare rdata with exp(addr).
  - On mismatch, err_count increments, saturating at DEPTH.
  - If err_count==0 before the increment, first_err_addr=addr.
  - Then advance as in WR_WAIT; after DEPTH-1 go to FIN.
- Timeout:
  - A wait counter resets on entry to each WAIT state.
  - If TIMEOUT consecutive WAIT cycles pass without ready, set timeout_err=1 and go to FIN immediately. The remaining sweep is skipped.
- FIN (1 cycle):
  - done=1; pass=(err_count==0 && !timeout_err); busy=0 on exit.
  - Next state IDLE.
  - Results hold until the next accepted start or rst.
- Nominal latency: start sampled at edge 0 → done high in cycle 4*DEPTH+1, which is 65 for DEPTH=16.
- ready=1 during a REQ cycle (stale acknowledge) is ignored. Only WAIT states consume ready.
- valid is never high on two consecutive cycles.
- addr, wr_rd and wdata are stable from REQ through the end of its WAIT.
- rst mid-test: all outputs return to reset values at the next edge with no done pulse. The partial sweep is abandoned.
- start asserted in the same cycle as FIN is ignored. A new test requires start while in IDLE.

Test Plan:
- Reset, then start with seed=8'hA5 against a correct RAM model → 16 writes with wdata = A5, A4, A7 … (A5^F=AA), then 16 reads. done in cycle 65, pass=1, err_count=0, timeout_err=0.
- Same run with the model flipping bit 0 of the read at address 5 and address 9 → err_count=2, first_err_addr=5, pass=0.
- RAM model never asserts ready on the 3rd write (addr=2) → after 8 WAIT cycles: timeout_err=1, done pulse, pass=0, and no reads issued.
- rst asserted during the read phase at addr=7 → next cycle valid=0, busy=0, err_count=0, and done never pulses. A subsequent start runs to pass=1.
- start pulsed repeatedly while busy, plus a stale ready held high through REQ cycles → test unaffected: exactly 32 valid pulses, each followed by a non-valid cycle, and the same results as the first scenario.
- DEPTH=10, ADDR_WIDTH=4, seed=0 → the sweep covers addresses 0..9 only (addr never reaches 10), done in cycle 41, pass=1.
